dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences the data-memory access of the MEM stage against a variable-latency memory using a req/ack handshake.
- Generates the pipeline stall that freezes PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Gates the writeback control fed into the MEM/WB register, so a bubble (ctlwb=0) enters WB on every stall cycle.
- Supplies the read data captured by MEM/WB.

Parameters:
- DATA_W, 32, data and address width.
- CNT_W, 8, width of the timeout counter.
- TIMEOUT_CYC, 255, number of WAIT cycles without ack before abort (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MEM_ctlm  in  2  bit0 MemRead, bit1 MemWrite, from EX/MEM.
- MEM_ctlwb  in  2  writeback control from EX/MEM.
- MEM_alu_out  in  DATA_W  effective address.
- MEM_wdata  in  DATA_W  store data.
- dmem_req  out  1  access request.
- dmem_we  out  1  1=write, 0=read.
- dmem_addr  out  DATA_W  access address.
- dmem_wdata  out  DATA_W  store data to memory.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  DATA_W  load data.
- MEM_rdata  out  DATA_W  load data to MEM/WB.
- MEM_ctlwb_g  out  2  gated ctlwb to MEM/WB.
- stall  out  1  freeze upstream pipeline registers.
- timeout_err  out  1  sticky timeout flag (optional feature).

Behaviour:
- access = MEM_ctlm[0] | MEM_ctlm[1]. If both bits are set, the access is a write; MEM_rdata is 0 for it.
- States:
  - IDLE (reset state).
  - WAIT: address, wdata and we are registered.
  - DONE: one cycle; the same instruction is still in MEM and must not re-issue.
- IDLE, no access:
  - dmem_req=0, stall=0, MEM_ctlwb_g=MEM_ctlwb, MEM_rdata=0.
- IDLE, access:
  - dmem_req=1 combinationally; addr, wdata and we are driven from the inputs.
  - If dmem_ack is high in the same cycle (zero-wait): stall=0, MEM_rdata=dmem_rdata, MEM_ctlwb_g=MEM_ctlwb, stay in IDLE.
  - Otherwise: stall=1, MEM_ctlwb_g=0, latch addr/wdata/we, go to WAIT.
- WAIT:
  - dmem_req=1 with the latched addr/wdata/we; stall=1, MEM_ctlwb_g=0.
  - On ack: capture dmem_rdata into rdata_q, go to DONE.
  - Upstream inputs are ignored because they are frozen.
- DONE:
  - dmem_req=0, stall=0, MEM_rdata=rdata_q, MEM_ctlwb_g=MEM_ctlwb.
  - Go to IDLE unconditionally; the next instruction enters MEM the following cycle.
- Latency: a load with N wait cycles (ack in the N-th WAIT cycle) stalls N+1 cycles; a zero-wait access stalls 0 cycles.
- An ack arriving in IDLE without req, or in DONE, is ignored.
- dmem_req may only drop after ack; no abort is allowed except timeout and reset.
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE, rdata_q=0, latched regs=0, timeout_err=0, counter=0.
  - Outputs follow the IDLE rules: dmem_req=0 when no access is present, stall=0.
  - The interrupted access is dropped.
  - The memory side must tolerate req falling without ack.

Optional Feature:
- Macro DMEM_TIMEOUT_EN, defined:
  - A CNT_W counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYC: go to DONE, rdata_q=32'hDEADBEEF, set timeout_err (sticky until reset).
  - MEM_ctlwb_g is forced to 0 in that DONE cycle, so writeback is suppressed.
  - An ack in the same cycle as the timeout wins.
- Macro not defined: WAIT persists indefinitely, timeout_err is tied 0, and no counter is built.

Decomposition:
- Shared package/header dmem_ctrl_pkg holds:
  - state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - ctlm bit indices (CTLM_RD=0, CTLM_WR=1);
  - ctlwb width;
  - the DEADBEEF poison constant.
- One sub-module, dmem_timeout_cnt (clear/enable/terminal-count), instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Zero-wait load: ctlm=01, addr=0x100, ack the same cycle with rdata=0x12345678 -> stall never 1, MEM_rdata=0x12345678 that cycle, MEM_ctlwb_g=MEM_ctlwb.
- 3-wait load: ack in the third WAIT cycle with rdata=0xCAFEF00D -> stall high 4 cycles, MEM_ctlwb_g=0 for those cycles, DONE cycle MEM_rdata=0xCAFEF00D with ctlwb passed through, dmem_req low in DONE.
- Store with 2 waits: ctlm=10, wdata=0xA5A5A5A5 -> dmem_we=1, addr/wdata stable until ack, req drops after ack, no re-issue in DONE.
- Back-to-back load then store: the second access's req rises only the cycle after DONE; no overlap.
- Reset mid-WAIT: rst_n low two cycles into WAIT -> immediately req=0, stall=0, state IDLE, MEM_rdata=0.
- DMEM_TIMEOUT_EN with TIMEOUT_CYC=4, ack never arrives -> stall drops after the timeout, DONE shows 0xDEADBEEF with ctlwb_g=0, timeout_err=1 until reset.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
package dmem_ctrl_pkg;

  localparam int unsigned CTLM_RD  = 0;
  localparam int unsigned CTLM_WR  = 1;
  localparam int unsigned CTLWB_W  = 2;
  localparam logic [31:0] POISON   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// WAIT-cycle counter with clear/enable; tc_c flags the cycle that reaches the limit.
module dmem_timeout_cnt #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // The enabled cycle whose increment would make the count reach TIMEOUT_CYC.
  assign tc_c = en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack handshake, pipeline stall, WB bubble gating.
// Optional WAIT timeout abort is built when DMEM_TIMEOUT_EN is defined.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         MEM_ctlm,
  input  logic [CTLWB_W-1:0] MEM_ctlwb,
  input  logic [DATA_W-1:0]  MEM_alu_out,
  input  logic [DATA_W-1:0]  MEM_wdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DATA_W-1:0]  MEM_rdata,
  output logic [CTLWB_W-1:0] MEM_ctlwb_g,
  output logic               stall,
  output logic               timeout_err
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (64'd1 << CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYC must fit in CNT_W bits and be nonzero");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, wdata_q, rdata_q, rdata_d;
  logic                we_q;
  logic                access, latch_c, cap_c, tmo_c, wb_kill_c;

  assign access = MEM_ctlm[CTLM_RD] | MEM_ctlm[CTLM_WR];

`ifdef DMEM_TIMEOUT_EN
  logic tmo_done_q;

  dmem_timeout_cnt #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (latch_c),
    .en    ((state_q == ST_WAIT) && !dmem_ack),
    .tc_c  (tmo_c)
  );

  // Remembers that the current DONE came from an abort, plus the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_done_q  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmo_done_q <= tmo_c;
      if (tmo_c) timeout_err <= 1'b1;
    end
  end

  assign wb_kill_c = tmo_done_q;
`else
  assign tmo_c       = 1'b0;
  assign wb_kill_c   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_c) begin
        addr_q  <= MEM_alu_out;
        wdata_q <= MEM_wdata;
        we_q    <= MEM_ctlm[CTLM_WR];
      end
      if (cap_c) rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = '0;
    dmem_wdata  = '0;
    stall       = 1'b0;
    MEM_ctlwb_g = MEM_ctlwb;
    MEM_rdata   = '0;
    latch_c     = 1'b0;
    cap_c       = 1'b0;
    rdata_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          dmem_req   = 1'b1;
          dmem_we    = MEM_ctlm[CTLM_WR];
          dmem_addr  = MEM_alu_out;
          dmem_wdata = MEM_wdata;
          if (dmem_ack) begin
            MEM_rdata = MEM_ctlm[CTLM_WR] ? '0 : dmem_rdata;
          end else begin
            stall       = 1'b1;
            MEM_ctlwb_g = '0;
            latch_c     = 1'b1;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dmem_req    = 1'b1;
        dmem_we     = we_q;
        dmem_addr   = addr_q;
        dmem_wdata  = wdata_q;
        stall       = 1'b1;
        MEM_ctlwb_g = '0;
        // Ack wins over a simultaneous timeout.
        if (dmem_ack) begin
          cap_c   = 1'b1;
          rdata_d = we_q ? '0 : dmem_rdata;
          state_d = ST_DONE;
        end else if (tmo_c) begin
          cap_c   = 1'b1;
          rdata_d = DATA_W'(POISON);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        MEM_rdata   = rdata_q;
        MEM_ctlwb_g = wb_kill_c ? '0 : MEM_ctlwb;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl; timeout scenario runs when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    ctlwb;
  } exp_t;

  logic          clk, rst_n;
  logic [1:0]    MEM_ctlm, MEM_ctlwb, MEM_ctlwb_g;
  logic [DW-1:0] MEM_alu_out, MEM_wdata, MEM_rdata;
  logic          dmem_req, dmem_we, dmem_ack, stall, timeout_err;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_access_ctrl #(.DATA_W(DW), .CNT_W(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_ctlm(MEM_ctlm), .MEM_ctlwb(MEM_ctlwb),
    .MEM_alu_out(MEM_alu_out), .MEM_wdata(MEM_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_rdata(MEM_rdata), .MEM_ctlwb_g(MEM_ctlwb_g),
    .stall(stall), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One MEM-stage access; the bench memory acks in WAIT cycle `waits` (0 = same cycle).
  task automatic do_access(input logic [1:0] ctlm, input logic [1:0] wb,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                           input int waits, input logic [DW-1:0] rd, input string tag);
    exp_t e;
    int   stalls = 0;
    e.rdata = ctlm[1] ? '0 : rd;
    e.ctlwb = wb;
    sb.push_back(e);
    @(negedge clk);
    MEM_ctlm = ctlm; MEM_ctlwb = wb; MEM_alu_out = addr; MEM_wdata = wd;
    dmem_ack = (waits == 0);
    dmem_rdata = (waits == 0) ? rd : 32'h0BAD_0000;
    #1;
    if (stall === 1'b1) stalls++;
    n_cmp++;
    if (dmem_req !== 1'b1 || dmem_we !== ctlm[1] || dmem_addr !== addr || dmem_wdata !== wd) begin
      n_err++;
      $display("FAIL %s issue: req=%b we=%b addr=%h wdata=%h, need req=1 we=%b addr=%h wdata=%h",
               tag, dmem_req, dmem_we, dmem_addr, dmem_wdata, ctlm[1], addr, wd);
    end
    if (waits == 0) begin
      n_cmp++;
      if (stall !== 1'b0) begin
        n_err++; $display("FAIL %s zero_wait_stall: got %b need 0", tag, stall);
      end
      e = sb.pop_front();
      n_cmp++;
      if (MEM_rdata !== e.rdata || MEM_ctlwb_g !== e.ctlwb) begin
        n_err++;
        $display("FAIL %s zero_wait_out: rdata=%h ctlwb_g=%b need %h %b", tag, MEM_rdata, MEM_ctlwb_g, e.rdata, e.ctlwb);
      end
      return;
    end
    n_cmp++;
    if (MEM_ctlwb_g !== 2'b00) begin
      n_err++; $display("FAIL %s entry_bubble: ctlwb_g=%b need 00", tag, MEM_ctlwb_g);
    end
    for (int i = 1; i <= waits; i++) begin
      @(negedge clk);
      MEM_ctlm = ~ctlm; MEM_alu_out = ~addr; MEM_wdata = ~wd;
      dmem_ack = (i == waits);
      dmem_rdata = (i == waits) ? rd : 32'h0BAD_0000 + DW'(i);
      #1;
      if (stall === 1'b1) stalls++;
      n_cmp++;
      if (dmem_req !== 1'b1 || dmem_we !== ctlm[1] || dmem_addr !== addr || dmem_wdata !== wd ||
          MEM_ctlwb_g !== 2'b00 || stall !== 1'b1) begin
        n_err++;
        $display("FAIL %s wait%0d: req=%b we=%b addr=%h wdata=%h ctlwb_g=%b stall=%b, need 1 %b %h %h 00 1",
                 tag, i, dmem_req, dmem_we, dmem_addr, dmem_wdata, MEM_ctlwb_g, stall, ctlm[1], addr, wd);
      end
    end
    @(negedge clk);
    MEM_ctlm = ctlm; MEM_alu_out = addr; MEM_wdata = wd;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    #1;
    if (stall === 1'b1) stalls++;
    n_cmp++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL %s done_req: req=%b stall=%b need 0 0", tag, dmem_req, stall);
    end
    e = sb.pop_front();
    n_cmp++;
    if (MEM_rdata !== e.rdata || MEM_ctlwb_g !== e.ctlwb) begin
      n_err++;
      $display("FAIL %s done_out: rdata=%h ctlwb_g=%b need %h %b", tag, MEM_rdata, MEM_ctlwb_g, e.rdata, e.ctlwb);
    end
    n_cmp++;
    if (stalls != waits + 1) begin
      n_err++; $display("FAIL %s stall_len: got %0d need %0d", tag, stalls, waits + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MEM_ctlm = 2'b00; MEM_ctlwb = 2'b11; MEM_alu_out = '0; MEM_wdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || MEM_rdata !== '0 || timeout_err !== 1'b0 ||
        MEM_ctlwb_g !== 2'b11 || dut.state_q !== 2'd0) begin
      n_err++;
      $display("FAIL reset: req=%b stall=%b rdata=%h terr=%b ctlwb_g=%b st=%0d, need 0 0 0 0 11 0",
               dmem_req, stall, MEM_rdata, timeout_err, MEM_ctlwb_g, dut.state_q);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_idle();
    @(negedge clk);
    MEM_ctlm = 2'b00; MEM_ctlwb = 2'b10; dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || MEM_rdata !== '0 || MEM_ctlwb_g !== 2'b10) begin
      n_err++;
      $display("FAIL idle: req=%b stall=%b rdata=%h ctlwb_g=%b need 0 0 0 10", dmem_req, stall, MEM_rdata, MEM_ctlwb_g);
    end
  endtask

  task automatic test_zero_wait();
    do_access(2'b01, 2'b11, 32'h0000_0100, 32'h0, 0, 32'h1234_5678, "zw_load");
    do_access(2'b10, 2'b00, 32'h0000_0200, 32'h1111_2222, 0, 32'h7777_7777, "zw_store");
  endtask

  task automatic test_wait_load();
    do_access(2'b01, 2'b01, 32'h0000_0140, 32'h0, 3, 32'hCAFE_F00D, "load3");
  endtask

  task automatic test_wait_store();
    do_access(2'b10, 2'b00, 32'h0000_0300, 32'hA5A5_A5A5, 2, 32'h0, "store2");
    do_access(2'b11, 2'b01, 32'h0000_0304, 32'h3C3C_3C3C, 1, 32'h9999_9999, "rdwr1");
  endtask

  task automatic test_back_to_back();
    do_access(2'b01, 2'b11, 32'h0000_0400, 32'h0, 1, 32'h0BEE_F123, "b2b_load");
    do_access(2'b10, 2'b00, 32'h0000_0404, 32'hFEED_0001, 2, 32'h0, "b2b_store");
    do_access(2'b01, 2'b10, 32'h0000_0408, 32'h0, 0, 32'h600D_D00D, "b2b_zw");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    MEM_ctlm = 2'b01; MEM_ctlwb = 2'b11; MEM_alu_out = 32'h500; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (stall !== 1'b1 || dmem_req !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_pre: stall=%b req=%b need 1 1", stall, dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b0; MEM_ctlm = 2'b00;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || MEM_rdata !== '0 || dut.state_q !== 2'd0) begin
      n_err++;
      $display("FAIL rst_wait: req=%b stall=%b rdata=%h st=%0d need 0 0 0 0", dmem_req, stall, MEM_rdata, dut.state_q);
    end
    @(negedge clk); rst_n = 1'b1;
    do_access(2'b01, 2'b01, 32'h0000_0600, 32'h0, 0, 32'h1357_9BDF, "post_rst");
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   stalls = 0;
    int   guard  = 0;
    e.rdata = 32'hDEAD_BEEF; e.ctlwb = 2'b00;
    sb.push_back(e);
    @(negedge clk);
    MEM_ctlm = 2'b01; MEM_ctlwb = 2'b11; MEM_alu_out = 32'h700; dmem_ack = 1'b0;
    #1;
    while (stall === 1'b1 && guard < 50) begin
      stalls++; guard++;
      @(negedge clk); #1;
    end
    n_cmp++;
    if (guard >= 50 || stalls != TMO + 1) begin
      n_err++; $display("FAIL tmo_stall_len: got %0d need %0d", stalls, TMO + 1);
    end
    e = sb.pop_front();
    n_cmp++;
    if (MEM_rdata !== e.rdata || MEM_ctlwb_g !== e.ctlwb || timeout_err !== 1'b1 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_done: rdata=%h ctlwb_g=%b terr=%b req=%b need %h %b 1 0",
               MEM_rdata, MEM_ctlwb_g, timeout_err, dmem_req, e.rdata, e.ctlwb);
    end
    @(negedge clk); MEM_ctlm = 2'b00; #1;
    n_cmp++;
    if (timeout_err !== 1'b1 || MEM_ctlwb_g !== 2'b11) begin
      n_err++; $display("FAIL tmo_sticky: terr=%b ctlwb_g=%b need 1 11", timeout_err, MEM_ctlwb_g);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_err++; $display("FAIL tmo_clear: terr=%b need 0", timeout_err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_zero_wait();
    test_wait_load();
    test_wait_store();
    test_back_to_back();
    test_idle();
    test_reset_mid_wait();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d left need 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
